// File: rtl/boot_loader.sv
// Boot loader front-end: synchronizes external program/strobe pins and streams nibbles into CPU memory.
// Optional running XOR checksum is enabled by defining BOOT_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module boot_loader #(
  parameter int DATA_WIDTH    = 4,
  parameter int ADDR_WIDTH    = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  prog_i,
  input  logic                  strobe_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  bl_programm_o,
  output logic [DATA_WIDTH-1:0] bl_data_o,
  output logic [ADDR_WIDTH-1:0] bl_address_o,
  output logic                  bl_write_en_mem_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] checksum_o
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ARMED  = 3'd2,
    S_WRITE  = 3'd3,
    S_FULL   = 3'd4
  } state_t;

  state_t state, state_n;

  logic                  prog_q1, prog_s;
  logic                  strb_q1, strb_s, strb_d;
  logic                  strb_edge;
  logic [CNT_W-1:0]      cnt;
  logic                  pending;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  done_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prog_q1 <= 1'b0;
      prog_s  <= 1'b0;
      strb_q1 <= 1'b0;
      strb_s  <= 1'b0;
      strb_d  <= 1'b0;
    end else begin
      prog_q1 <= prog_i;
      prog_s  <= prog_q1;
      strb_q1 <= strobe_i;
      strb_s  <= strb_q1;
      strb_d  <= strb_s;
    end
  end

  assign strb_edge = strb_s & ~strb_d;

  always_comb begin
    state_n = state;
    capture = 1'b0;
    case (state)
      S_IDLE: begin
        if (prog_s) state_n = S_SETTLE;
      end
      S_SETTLE: begin
        if (!prog_s) begin
          state_n = S_IDLE;
        end else begin
          capture = strb_edge & ~pending;
          // A nibble caught on the final settle cycle still goes straight to WRITE.
          if (cnt == CNT_LAST) state_n = (pending || capture) ? S_WRITE : S_ARMED;
        end
      end
      S_ARMED: begin
        if (!prog_s) begin
          state_n = S_IDLE;
        end else if (strb_edge) begin
          capture = 1'b1;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!prog_s)                state_n = S_IDLE;
        else if (addr == ADDR_LAST) state_n = S_FULL;
        else                        state_n = S_ARMED;
      end
      S_FULL: begin
        if (!prog_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pending <= 1'b0;
      addr    <= '0;
      data_r  <= '0;
      done_r  <= 1'b0;
    end else begin
      state <= state_n;

      if (state == S_SETTLE) cnt <= cnt + CNT_W'(1);
      else                   cnt <= '0;

      if (state != S_SETTLE) pending <= 1'b0;
      else if (capture)      pending <= 1'b1;

      // Address wraps to 0 after the last location.
      if (state == S_WRITE)     addr <= addr + ADDR_WIDTH'(1);
      else if (state == S_IDLE) addr <= '0;

      if (capture) data_r <= data_i;

      if (state == S_IDLE && state_n == S_SETTLE)   done_r <= 1'b0;
      else if (state == S_WRITE && addr == ADDR_LAST) done_r <= 1'b1;
    end
  end

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cksum;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                                cksum <= '0;
    else if (state == S_IDLE && state_n == S_SETTLE) cksum <= '0;
    else if (state == S_WRITE)                  cksum <= cksum ^ data_r;
  end

  assign checksum_o = cksum;
`else
  assign checksum_o = '0;
`endif

  assign bl_programm_o     = (state != S_IDLE);
  assign bl_write_en_mem_o = (state == S_WRITE);
  assign bl_address_o      = addr;
  assign bl_data_o         = data_r;
  assign done_o            = done_r;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: scoreboard of expected writes plus directed corner-case sequences.
`timescale 1ns/1ps
module tb_boot_loader;

  localparam int S = 8;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       prog_i;
  logic       strobe_i;
  logic [3:0] data_i;
  logic       bl_programm_o;
  logic [3:0] bl_data_o;
  logic [3:0] bl_address_o;
  logic       bl_write_en_mem_o;
  logic       done_o;
  logic [3:0] checksum_o;

  boot_loader #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .SETTLE_CYCLES(S)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .prog_i(prog_i), .strobe_i(strobe_i), .data_i(data_i),
    .bl_programm_o(bl_programm_o), .bl_data_o(bl_data_o), .bl_address_o(bl_address_o),
    .bl_write_en_mem_o(bl_write_en_mem_o), .done_o(done_o), .checksum_o(checksum_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [3:0] data; logic [3:0] addr; } wr_t;
  typedef struct { logic [3:0] data; logic [3:0] exp_addr; } vec_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   wr_n   = 0;
  int   rd     = 0;
  logic [3:0] exp_ck;
  logic [3:0] obs_a[64];
  logic [3:0] obs_d[64];
  int         obs_c[64];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Write log: every cycle with the write pulse high is one observed write.
  always @(negedge clk_i) begin
    if (bl_write_en_mem_o && wr_n < 64) begin
      obs_a[wr_n] <= bl_address_o;
      obs_d[wr_n] <= bl_data_o;
      obs_c[wr_n] <= cyc;
      wr_n        <= wr_n + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] ck_exp();
`ifdef BOOT_LOADER_CHECKSUM_EN
    return exp_ck;
`else
    return 4'h0;
`endif
  endfunction

  task automatic push(input logic [3:0] d, input logic [3:0] a);
    wr_t w;
    w.data = d;
    w.addr = a;
    exp_q.push_back(w);
    exp_ck = exp_ck ^ d;
  endtask

  task automatic strobe(input logic [3:0] d);
    data_i = d;
    tick(3);
    strobe_i = 1'b1;
    tick(3);
    strobe_i = 1'b0;
    tick(3);
  endtask

  task automatic drain(input string nm);
    wr_t e;
    while (rd < wr_n) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_write: got addr %0h data %0h expected no write", nm, obs_a[rd], obs_d[rd]);
      end else begin
        e = exp_q.pop_front();
        chk({nm, "_addr"}, obs_a[rd], e.addr);
        chk({nm, "_data"}, obs_d[rd], e.data);
      end
      rd++;
    end
  endtask

  initial begin
    vec_t basic[3];
    int   w0;
    int   rise_c;

    basic[0] = '{data: 4'h3, exp_addr: 4'h0};
    basic[1] = '{data: 4'hA, exp_addr: 4'h1};
    basic[2] = '{data: 4'hF, exp_addr: 4'h2};

    reset_i = 1'b1; prog_i = 1'b0; strobe_i = 1'b0; data_i = 4'h0; exp_ck = 4'h0;
    tick(2);
    chk("rst_programm", bl_programm_o, 0);
    chk("rst_we", bl_write_en_mem_o, 0);
    chk("rst_addr", bl_address_o, 0);
    chk("rst_data", bl_data_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_cksum", checksum_o, 0);
    reset_i = 1'b0;
    tick(2);

    // Basic load
    exp_ck = 4'h0;
    w0 = wr_n;
    prog_i = 1'b1;
    tick(2);
    chk("basic_programm_early", bl_programm_o, 0);
    tick(1);
    chk("basic_programm_rise", bl_programm_o, 1);
    tick(S + 1);
    for (int i = 0; i < 3; i++) begin
      push(basic[i].data, basic[i].exp_addr);
      strobe(basic[i].data);
      drain("basic");
    end
    chk("basic_count", wr_n - w0, 3);
    chk("basic_cksum", checksum_o, ck_exp());
    prog_i = 1'b0;
    tick(2);
    chk("basic_programm_hold", bl_programm_o, 1);
    tick(1);
    chk("basic_programm_fall", bl_programm_o, 0);
    tick(3);

    // Early strobe during SETTLE; second strobe during SETTLE is dropped
    exp_ck = 4'h0;
    w0 = wr_n;
    data_i = 4'h5;
    tick(2);
    prog_i = 1'b1;
    tick(2);
    strobe_i = 1'b1;
    push(4'h5, 4'h0);
    tick(1);
    chk("early_programm_rise", bl_programm_o, 1);
    rise_c = cyc;
    tick(2);
    strobe_i = 1'b0;
    tick(3);
    data_i = 4'h9;
    strobe_i = 1'b1;
    tick(3);
    strobe_i = 1'b0;
    tick(6);
    drain("early");
    chk("early_count", wr_n - w0, 1);
    if (wr_n > w0) chk("early_latency_ok", (obs_c[w0] - rise_c) >= S, 1);
    chk("early_data_hold", bl_data_o, 4'h5);
    chk("early_next_addr", bl_address_o, 4'h1);
    prog_i = 1'b0;
    tick(4);

    // Full memory
    exp_ck = 4'h0;
    w0 = wr_n;
    prog_i = 1'b1;
    tick(3 + S + 1);
    for (int i = 0; i < 16; i++) begin
      push(4'(i), 4'(i));
      strobe(4'(i));
    end
    drain("full");
    chk("full_count", wr_n - w0, 16);
    chk("full_done", done_o, 1);
    chk("full_addr_wrap", bl_address_o, 0);
    strobe(4'h7);
    drain("full_extra");
    chk("full_count_after_17th", wr_n - w0, 16);
    chk("full_cksum", checksum_o, ck_exp());
    prog_i = 1'b0;
    tick(4);
    chk("full_idle_programm", bl_programm_o, 0);
    chk("full_idle_done", done_o, 1);

    // Abort with prog falling during the fifth write
    exp_ck = 4'h0;
    w0 = wr_n;
    prog_i = 1'b1;
    tick(4);
    chk("abort_done_cleared", done_o, 0);
    tick(S);
    for (int i = 0; i < 4; i++) begin
      push(4'(8 + i), 4'(i));
      strobe(4'(8 + i));
    end
    data_i = 4'h2;
    tick(3);
    strobe_i = 1'b1;
    push(4'h2, 4'h4);
    tick(1);
    prog_i = 1'b0;
    tick(2);
    chk("abort_inflight_we", bl_write_en_mem_o, 1);
    chk("abort_inflight_addr", bl_address_o, 4'h4);
    tick(1);
    chk("abort_programm_low", bl_programm_o, 0);
    strobe_i = 1'b0;
    tick(3);
    strobe(4'hE);
    drain("abort");
    chk("abort_count", wr_n - w0, 5);
    exp_ck = 4'h0;
    prog_i = 1'b1;
    tick(3);
    chk("restart_programm", bl_programm_o, 1);
    chk("restart_done", done_o, 0);
    chk("restart_addr", bl_address_o, 0);
    tick(S + 1);
    push(4'hC, 4'h0);
    strobe(4'hC);
    drain("restart");
    chk("restart_cksum", checksum_o, ck_exp());
    prog_i = 1'b0;
    tick(4);

    // Reset during a write with prog held high
    exp_ck = 4'h0;
    prog_i = 1'b1;
    tick(3 + S + 1);
    push(4'h1, 4'h0);
    strobe(4'h1);
    drain("prereset");
    data_i = 4'h6;
    tick(3);
    strobe_i = 1'b1;
    tick(3);
    chk("reset_in_write_we", bl_write_en_mem_o, 1);
    reset_i = 1'b1;
    #1;
    chk("reset_async_we", bl_write_en_mem_o, 0);
    chk("reset_async_programm", bl_programm_o, 0);
    chk("reset_async_addr", bl_address_o, 0);
    chk("reset_async_data", bl_data_o, 0);
    chk("reset_async_done", done_o, 0);
    chk("reset_async_cksum", checksum_o, 0);
    strobe_i = 1'b0;
    tick(2);
    reset_i = 1'b0;
    tick(2);
    chk("reload_programm_early", bl_programm_o, 0);
    tick(1);
    chk("reload_programm_rise", bl_programm_o, 1);
    exp_ck = 4'h0;
    tick(S + 1);
    push(4'h4, 4'h0);
    strobe(4'h4);
    drain("reload");
    chk("reload_cksum", checksum_o, ck_exp());

    // One-cycle strobe glitch yields exactly one write
    w0 = wr_n;
    data_i = 4'hB;
    tick(3);
    strobe_i = 1'b1;
    push(4'hB, 4'h1);
    tick(1);
    strobe_i = 1'b0;
    tick(6);
    drain("glitch");
    chk("glitch_count", wr_n - w0, 1);
    prog_i = 1'b0;
    tick(4);

    drain("final");
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
